mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Memory-access stage of the pipelined MIPS core plus the MEM/WB register.
// It takes the EX/MEM outputs, drives a variable-latency data-memory bus with
// a req/ready handshake, and raises StallM while an access is outstanding so
// hazard logic can freeze EX/MEM and the earlier stages. While stalled, the
// W stage receives bubbles. Completed instructions are registered onto the
// W outputs.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When this macro is defined, a BUSY access that waits TIMEOUT cycles
//   without DMemReady is aborted. The instruction retires as a no-write
//   bubble, and the sticky MemErr flag is set. The flag clears only on rst.
//   When the macro is undefined, BUSY waits indefinitely and the MemErr port
//   does not exist.
//
// Parameters:
//   TIMEOUT    max BUSY cycles before abort (MEM_TIMEOUT_EN only), >= 2
//
// Ports:
//   CLK, rst              clock (rising edge), async active-high reset
//   RegWriteM..WriteRegM  M-stage control and data from EX/MEM
//   DMemReq/We/Addr/Wdata data-memory request side (combinational)
//   DMemRdata, DMemReady  data-memory response side
//   StallM                combinational freeze for upstream stages
//   RegWriteW..WriteRegW  registered MEM/WB outputs feeding writeback
//   MemErr                sticky timeout flag (MEM_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemToRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WritedataM,
  input  logic [4:0]  WriteRegM,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWdata,
  input  logic [31:0] DMemRdata,
  input  logic        DMemReady,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemToRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW
`ifdef MEM_TIMEOUT_EN
  ,
  output logic        MemErr
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t r_state;

  logic w_mop;
  logic w_isLoad;
  logic w_abort;
  logic w_req;
  logic w_stall;

  // A wait limit below 2 would abort every access in its first BUSY cycle.
  if (TIMEOUT < 2) begin : g_badTimeout
    $error("mem_wb_stage: TIMEOUT must be >= 2");
  end

  // If both MemToRegM and MemWriteM are set, the access is a store, so only
  // a pure MemToRegM counts as a load.
  assign w_mop    = MemToRegM | MemWriteM;
  assign w_isLoad = MemToRegM & ~MemWriteM;

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] r_waitCnt;
  logic            r_memErr;

  // If DMemReady arrives in the abort cycle, the access completes normally.
  assign w_abort = (r_state == BUSY) & ~DMemReady &
                   (r_waitCnt == CntW'(TIMEOUT - 1));
  assign MemErr  = r_memErr;
`else
  assign w_abort = 1'b0;
`endif

  // The request and the stall are decoded from the state and the live M
  // inputs. Upstream holds those inputs stable while StallM is high.
  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        w_req   = w_mop;
        w_stall = w_mop & ~DMemReady;
      end
      BUSY: begin
        w_req   = ~w_abort;
        w_stall = ~DMemReady & ~w_abort;
      end
      default: begin
        w_req   = 1'b0;
        w_stall = 1'b0;
      end
    endcase
  end

  // The request is masked by rst so the bus drops at once on an async reset,
  // even though the M inputs may still show a memory op.
  assign DMemReq   = w_req & ~rst;
  assign DMemWe    = MemWriteM;
  assign DMemAddr  = {ALUOutM[31:2], 2'b00};
  assign DMemWdata = WritedataM;
  assign StallM    = w_stall;

  // Access FSM and MEM/WB register. A bubble clears only the write-enable
  // bits and leaves the data fields holding their values. ReadDataW moves
  // only when a load completes.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      ReadDataW <= 32'h0;
      ALUOutW   <= 32'h0;
      WriteRegW <= 5'h0;
`ifdef MEM_TIMEOUT_EN
      r_waitCnt <= '0;
      r_memErr  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mop & ~DMemReady) begin
            r_state   <= BUSY;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_waitCnt <= '0;
`endif
          end else begin
            RegWriteW <= RegWriteM;
            MemToRegW <= w_isLoad;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            if (w_mop & w_isLoad) begin
              ReadDataW <= DMemRdata;
            end
          end
        end
        BUSY: begin
          if (DMemReady) begin
            r_state   <= IDLE;
            RegWriteW <= RegWriteM;
            MemToRegW <= w_isLoad;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            if (w_isLoad) begin
              ReadDataW <= DMemRdata;
            end
          end else if (w_abort) begin
            // The aborted instruction retires without writing anything.
            r_state   <= IDLE;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
`ifdef MEM_TIMEOUT_EN
            r_memErr  <= 1'b1;
`endif
          end else begin
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_waitCnt <= r_waitCnt + 1'b1;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
// This testbench drives directed steps into mem_wb_stage. It pushes the
// expected MEM/WB contents into a scoreboard when an instruction is presented
// and pops them when the stage retires the instruction. It also checks the
// stall and bus behaviour on every cycle in between.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        rst;
  logic        RegWriteM, MemToRegM, MemWriteM;
  logic [31:0] ALUOutM, WritedataM;
  logic [4:0]  WriteRegM;
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr, DMemWdata, DMemRdata;
  logic        DMemReady;
  logic        StallM;
  logic        RegWriteW, MemToRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;
`ifdef MEM_TIMEOUT_EN
  logic        MemErr;
`endif

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .CLK(CLK), .rst(rst),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WritedataM(WritedataM), .WriteRegM(WriteRegM),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWdata(DMemWdata), .DMemRdata(DMemRdata), .DMemReady(DMemReady),
    .StallM(StallM),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW)
`ifdef MEM_TIMEOUT_EN
    , .MemErr(MemErr)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } wbExp_t;

  wbExp_t      sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] expRead = 32'h0;
  logic [31:0] expAlu  = 32'h0;
  logic [4:0]  expWr   = 5'h0;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The W fields must show a bubble and hold their data fields.
  task automatic checkBubble(input string tag);
    checkOutput({tag, ".RegWriteW"}, RegWriteW, 0);
    checkOutput({tag, ".MemToRegW"}, MemToRegW, 0);
    checkOutput({tag, ".ReadDataW"}, ReadDataW, expRead);
    checkOutput({tag, ".ALUOutW"},   ALUOutW,   expAlu);
    checkOutput({tag, ".WriteRegW"}, WriteRegW, expWr);
  endtask

  // Present one instruction and answer it after 'waits' wait cycles. The
  // task is entered just after a rising edge and leaves just after one.
  task automatic applyStimulus(input string tag, input logic rw, input logic m2r,
                               input logic mw, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [4:0] wr,
                               input int waits, input logic [31:0] rdata);
    wbExp_t e;
    logic   mop, isLoad, ready;
    mop    = m2r | mw;
    isLoad = m2r & ~mw;
    RegWriteM  = rw;
    MemToRegM  = m2r;
    MemWriteM  = mw;
    ALUOutM    = alu;
    WritedataM = wd;
    WriteRegM  = wr;
    e.rw  = rw;
    e.m2r = isLoad;
    e.rd  = isLoad ? rdata : expRead;
    e.alu = alu;
    e.wr  = wr;
    sb.push_back(e);
    for (int c = 0; c <= waits; c++) begin
      ready     = !mop || (c == waits);
      // Without a request, an asserted ready with junk data must be ignored.
      DMemReady = ready;
      DMemRdata = (mop && ready) ? rdata : 32'h0BAD0BAD;
      #1;
      checkOutput({tag, ".StallM"},  StallM,  mop && !ready);
      checkOutput({tag, ".DMemReq"}, DMemReq, mop);
      if (mop) begin
        checkOutput({tag, ".DMemWe"},   DMemWe,   mw);
        checkOutput({tag, ".DMemAddr"}, DMemAddr, alu & 32'hFFFF_FFFC);
        if (mw) checkOutput({tag, ".DMemWdata"}, DMemWdata, wd);
      end
      @(posedge CLK); #1;
      if (mop && !ready) begin
        checkBubble(tag);
      end else if (sb.size() == 0) begin
        checkOutput({tag, ".sbUnderflow"}, 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput({tag, ".RegWriteW"}, RegWriteW, e.rw);
        checkOutput({tag, ".MemToRegW"}, MemToRegW, e.m2r);
        checkOutput({tag, ".ReadDataW"}, ReadDataW, e.rd);
        checkOutput({tag, ".ALUOutW"},   ALUOutW,   e.alu);
        checkOutput({tag, ".WriteRegW"}, WriteRegW, e.wr);
        expRead = e.rd;
        expAlu  = e.alu;
        expWr   = e.wr;
      end
    end
    DMemReady = 1'b0;
  endtask

  task automatic clearInputs();
    RegWriteM  = 1'b0;
    MemToRegM  = 1'b0;
    MemWriteM  = 1'b0;
    ALUOutM    = 32'h0;
    WritedataM = 32'h0;
    WriteRegM  = 5'h0;
    DMemReady  = 1'b0;
    DMemRdata  = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst.DMemReq",   DMemReq,   0);
    checkOutput("rst.RegWriteW", RegWriteW, 0);
    checkOutput("rst.MemToRegW", MemToRegW, 0);
    checkOutput("rst.ReadDataW", ReadDataW, 0);
    checkOutput("rst.ALUOutW",   ALUOutW,   0);
    checkOutput("rst.WriteRegW", WriteRegW, 0);
`ifdef MEM_TIMEOUT_EN
    checkOutput("rst.MemErr",    MemErr,    0);
`endif
    rst = 1'b0;
    @(posedge CLK); #1;

    applyStimulus("load0w",  1, 1, 0, 32'h10, 32'h0, 5'd5, 0, 32'hDEADBEEF);
    applyStimulus("load3w",  1, 1, 0, 32'h10, 32'h0, 5'd5, 3, 32'hCAFEF00D);
    applyStimulus("store2w", 0, 0, 1, 32'h23, 32'h12345678, 5'd7, 2, 32'h0);
    applyStimulus("aluOp",   1, 0, 0, 32'h55, 32'h0, 5'd9, 0, 32'h0);
    applyStimulus("bothSet", 1, 1, 1, 32'h47, 32'hA5A5A5A5, 5'd11, 0, 32'h0);
    applyStimulus("load1w",  1, 1, 0, 32'h2C, 32'h0, 5'd20, 1, 32'h01234567);

    // Stall a load for two cycles, then reset asynchronously between edges.
    RegWriteM = 1'b1; MemToRegM = 1'b1; MemWriteM = 1'b0;
    ALUOutM = 32'h80; WriteRegM = 5'd3; DMemReady = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    checkOutput("preRst.StallM", StallM, 1);
    rst = 1'b1;
    #1;
    checkOutput("midRst.DMemReq",   DMemReq,   0);
    checkOutput("midRst.RegWriteW", RegWriteW, 0);
    checkOutput("midRst.MemToRegW", MemToRegW, 0);
    checkOutput("midRst.ReadDataW", ReadDataW, 0);
    checkOutput("midRst.ALUOutW",   ALUOutW,   0);
    checkOutput("midRst.WriteRegW", WriteRegW, 0);
    expRead = 32'h0; expAlu = 32'h0; expWr = 5'h0;
    clearInputs();
    @(posedge CLK); #1;
    rst = 1'b0;
    applyStimulus("postRst", 1, 1, 0, 32'h44, 32'h0, 5'd4, 1, 32'h89ABCDEF);

`ifdef MEM_TIMEOUT_EN
    // With TIMEOUT = 4, a load that never gets ready stalls for four cycles
    // and is aborted in the fifth.
    RegWriteM = 1'b1; MemToRegM = 1'b1; MemWriteM = 1'b0;
    ALUOutM = 32'h100; WriteRegM = 5'd12;
    DMemReady = 1'b0; DMemRdata = 32'h0BAD0BAD;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput("tmo.StallM",  StallM,  1);
      checkOutput("tmo.DMemReq", DMemReq, 1);
      @(posedge CLK); #1;
      checkBubble("tmo");
    end
    #1;
    checkOutput("tmoAbort.StallM",  StallM,  0);
    checkOutput("tmoAbort.DMemReq", DMemReq, 0);
    @(posedge CLK); #1;
    checkOutput("tmoDone.RegWriteW", RegWriteW, 0);
    checkOutput("tmoDone.MemToRegW", MemToRegW, 0);
    checkOutput("tmoDone.ReadDataW", ReadDataW, expRead);
    checkOutput("tmoDone.ALUOutW",   ALUOutW,   32'h100);
    checkOutput("tmoDone.WriteRegW", WriteRegW, 12);
    checkOutput("tmoDone.MemErr",    MemErr,    1);
    expAlu = 32'h100; expWr = 5'd12;
    applyStimulus("tmoNext", 1, 0, 0, 32'h66, 32'h0, 5'd13, 0, 32'h0);
    checkOutput("tmoSticky.MemErr", MemErr, 1);
    rst = 1'b1;
    #1;
    checkOutput("tmoRst.MemErr", MemErr, 0);
    clearInputs();
    @(posedge CLK); #1;
    rst = 1'b0;
`endif

    checkOutput("sbEmpty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
